// File: rtl/alu_div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and result constants.
package alu_div_seq_pkg;

    // IDLE -> RUN -> FIX -> IDLE; a zero divisor skips RUN.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } div_state_e;

    // Every quotient bit takes this value on divide-by-zero (all ones).
    localparam logic DivZeroFill = 1'b1;

endpackage

// File: rtl/alu_div_seq_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract the
// divisor, keep the difference on no borrow, otherwise restore.
module alu_div_seq_div_step
    import alu_div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] d,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] sum;
    logic [WIDTH:0]   diff;
    logic             unused_diff_msb;

    assign shifted = {r, dividend_bit};

    // WIDTH+1-bit subtract as shifted + ~{0,d} + 1; carry out set means no borrow.
    assign sum = {1'b0, shifted} + {1'b0, ~{1'b0, d}} + {{(WIDTH + 1){1'b0}}, 1'b1};

    assign q_bit = sum[WIDTH+1];
    assign diff  = sum[WIDTH:0];

    // A kept difference is below d, so its top bit is always zero.
    assign unused_diff_msb = diff[WIDTH];

    assign r_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle DIV/DIVU unit: one quotient bit per clock on operand magnitudes, signs applied
// in a final fix-up cycle. Quotient goes to LO, remainder to HI.
module alu_div_seq
    import alu_div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    localparam int unsigned      CntW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0]  LastCount  = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] DivZeroQuo = {WIDTH{DivZeroFill}};

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] r_q, r_d;          // partial remainder
    logic [WIDTH-1:0] q_q, q_d;          // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;          // divisor magnitude
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             zero_q, zero_d;    // divisor was zero for the current operation
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] step_r;
    logic             step_q;
    logic [WIDTH-1:0] rem_mag;

    assign a_neg = Sign & A[WIDTH-1];
    assign b_neg = Sign & B[WIDTH-1];

    // On divide-by-zero the dividend magnitude still sits in q_q and becomes the remainder.
    assign rem_mag = zero_q ? q_q : r_q;

    alu_div_seq_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .r            (r_q),
        .d            (d_q),
        .dividend_bit (q_q[WIDTH-1]),
        .r_next       (step_r),
        .q_bit        (step_q)
    );

    // Next-state and datapath control; flush wins over everything and leaves results intact.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        r_d        = r_q;
        q_d        = q_q;
        d_d        = d_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        zero_d     = zero_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        r_d       = '0;
                        q_d       = a_neg ? -A : A;
                        d_d       = b_neg ? -B : B;
                        quo_neg_d = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        zero_d    = (B == '0);
                        count_d   = '0;
                        state_d   = (B == '0) ? StFix : StRun;
                    end
                end
                StRun: begin
                    r_d     = step_r;
                    q_d     = {q_q[WIDTH-2:0], step_q};
                    count_d = count_q + CntW'(1);
                    if (count_q == LastCount) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    quo_d      = zero_q ? DivZeroQuo : (quo_neg_q ? -q_q : q_q);
                    rem_d      = rem_neg_q ? -rem_mag : rem_mag;
                    div_zero_d = zero_q;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, operand and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            r_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            zero_q     <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            r_q        <= r_d;
            q_q        <= q_d;
            d_q        <= d_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            zero_q     <= zero_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == StRun) || (state_q == StFix);
    assign done     = done_q;
    assign quo      = quo_q;
    assign rem      = rem_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: expected results are queued at issue time from a
// plain-arithmetic model and popped by an independent monitor whenever done pulses.
module tb_alu_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         flush;
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dz;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } res_t;

    res_t sb[$];
    res_t last_res;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_div_seq #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start),
        .flush    (flush),
        .Sign     (sign),
        .A        (a),
        .B        (b),
        .busy     (busy),
        .done     (done),
        .quo      (quo),
        .rem      (rem),
        .div_zero (dz)
    );

    always #5 clk = ~clk;

    // Reference: DIV/DIVU semantics with the divide-by-zero and overflow cases spelled out.
    function automatic res_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t t;
        t = '0;
        if (y == 0) begin
            t.q  = '1;
            t.r  = x;
            t.dz = 1'b1;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            t.q = 32'h8000_0000;
            t.r = '0;
        end else if (s) begin
            t.q = $signed(x) / $signed(y);
            t.r = $signed(x) % $signed(y);
        end else begin
            t.q = x / y;
            t.r = x % y;
        end
        return t;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            5:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit push);
        @(posedge clk);
        #1;
        sign  = s;
        a     = x;
        b     = y;
        start = 1'b1;
        if (push) sb.push_back(model(s, x, y));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
        end
    endtask

    // Issue, then count busy cycles and the cycle index of done relative to acceptance.
    task automatic measure(input string name, input logic s, input logic [W-1:0] x,
                           input logic [W-1:0] y, input int exp_done);
        int done_at;
        int busy_cnt;
        done_at  = 0;
        busy_cnt = 0;
        issue(s, x, y, 1'b1);
        for (int i = 1; i <= 60 && done_at == 0; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_at = i;
        end
        chk({name, "_done_cycle"}, 32'(done_at), 32'(exp_done));
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_done - 1));
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_busy"}, {31'b0, busy}, '0);
        chk({name, "_done"}, {31'b0, done}, '0);
        chk({name, "_quo"}, quo, '0);
        chk({name, "_rem"}, rem, '0);
        chk({name, "_div_zero"}, {31'b0, dz}, '0);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation, with busy low.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && done) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got quo=%h rem=%h dz=%b expected no done",
                         quo, rem, dz);
            end else begin
                e = sb.pop_front();
                last_res = e;
                if ({quo, rem, dz, busy} !== {e.q, e.r, e.dz, 1'b0}) begin
                    n_bad++;
                    $display("FAIL result: got quo=%h rem=%h dz=%b busy=%b expected quo=%h rem=%h dz=%b busy=0",
                             quo, rem, dz, busy, e.q, e.r, e.dz);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        sign     = 1'b0;
        a        = '0;
        b        = '0;
        last_res = '0;
        #12;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Latency and basic results
        measure("divu_100_7", 1'b0, 32'd100, 32'd7, 34);
        measure("divu_5_0", 1'b0, 32'd5, 32'd0, 2);

        // Sign handling and boundaries
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);          wait_done("div_m7_2");
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);          wait_done("div_7_m2");
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  wait_done("div_ovf");
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  wait_done("divu_ovf_ops");
        issue(1'b1, 32'h8000_0000, 32'd0, 1'b1);          wait_done("div_min_0");
        issue(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b1);          wait_done("div_m7_0");
        issue(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);  wait_done("div_max_min");
        issue(1'b0, 32'd0, 32'd9, 1'b1);                  wait_done("divu_0_9");

        // Flush at cycle 10 of a running divide: no done, results untouched
        issue(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'b0, busy}, '0);
        chk("flush_quo_hold", quo, last_res.q);
        chk("flush_rem_hold", rem, last_res.r);
        chk("flush_dz_hold", {31'b0, dz}, {31'b0, last_res.dz});
        repeat (40) @(negedge clk);

        // Start together with flush is refused
        @(posedge clk);
        #1;
        sign  = 1'b0;
        a     = 32'd9;
        b     = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("start_flush_busy", {31'b0, busy}, '0);
        repeat (40) @(negedge clk);

        // Start while busy is ignored
        issue(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1);
        repeat (5) @(negedge clk);
        sign  = 1'b0;
        a     = 32'd1234;
        b     = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start_while_busy");
        repeat (5) @(negedge clk);

        // Back-to-back: second start presented in the done cycle
        issue(1'b0, 32'd1000, 32'd3, 1'b1);
        wait_done("b2b_first");
        sign  = 1'b1;
        a     = 32'hFFFF_FFCE;
        b     = 32'd7;
        start = 1'b1;
        sb.push_back(model(1'b1, 32'hFFFF_FFCE, 32'd7));
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        wait_done("b2b_second");

        // Asynchronous reset in the middle of an operation
        issue(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("mid_reset");
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Randomized signed/unsigned operands with corner values mixed in
        for (int n = 0; n < 1500; n++) begin
            logic          s;
            logic [W-1:0]  x;
            logic [W-1:0]  y;
            s = 1'($urandom_range(0, 1));
            x = pick();
            y = pick();
            issue(s, x, y, 1'b1);
            wait_done("random");
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
